// File: rtl/csr_pkg.sv
// Shared CSR definitions: machine-mode CSR addresses, Zicsr op encodings,
// mstatus bit positions and the controller state encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    typedef enum logic [1:0] {
        OP_RD = 2'b00,
        OP_RW = 2'b01,
        OP_RS = 2'b10,
        OP_RC = 2'b11
    } csr_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_I_RD,
        S_I_WAIT,
        S_I_WR,
        S_T_EPC,
        S_T_CAUSE,
        S_T_TVAL,
        S_T_ST_RD,
        S_T_ST_WAIT,
        S_T_ST_WR
    } ctrl_state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational new-value compute: Zicsr RW/RS/RC result and the
// mstatus update applied on trap entry.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter logic [1:0] MPP_VALUE = 2'b11
) (
    input  csr_op_e           i_op,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_new,
    output logic [DATA_W-1:0] o_mstatus
);

    always_comb begin
        o_new = i_old;
        case (i_op)
            OP_RW:   o_new = i_wdata;
            OP_RS:   o_new = i_old | i_wdata;
            OP_RC:   o_new = i_old & ~i_wdata;
            default: o_new = i_old;
        endcase
    end

    // Trap entry stacks MIE into MPIE, disables interrupts and records the previous privilege.
    always_comb begin
        o_mstatus                                = i_old;
        o_mstatus[MSTATUS_MPIE]                  = i_old[MSTATUS_MIE];
        o_mstatus[MSTATUS_MIE]                   = 1'b0;
        o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_VALUE;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Single-port CSR access sequencer: Zicsr read-modify-write and trap entry writes.
// Optional read-only write check enabled by defining CSR_RO_CHECK_EN.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 12,
    parameter logic [1:0] MPP_VALUE = 2'b11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wr_en,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_illegal,
    input  logic              trap_valid,
    input  logic [DATA_W-1:0] trap_pc,
    input  logic [DATA_W-1:0] trap_cause,
    input  logic [DATA_W-1:0] trap_tval,
    output logic              trap_done,
    output logic [ADDR_W-1:0] csr_addr,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic              csr_we,
    output logic [DATA_W-1:0] csr_wdata
);

    localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(CSR_MSTATUS);
    localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(CSR_MEPC);
    localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(CSR_MCAUSE);
    localparam logic [ADDR_W-1:0] A_MTVAL   = ADDR_W'(CSR_MTVAL);

    ctrl_state_e       r_state;
    ctrl_state_e       w_next;
    csr_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_old;

    logic              w_accept;
    logic              w_eff_wr;
    logic              w_illegal;
    logic [DATA_W-1:0] w_new;
    logic [DATA_W-1:0] w_mstatus;

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // the requester holds its fields stable until then, and trap entry blocks acceptance.
    assign req_ready = (r_state == S_IDLE) && !trap_valid;
    assign w_accept  = req_valid && req_ready;
    assign w_eff_wr  = r_wr_en && (r_op != OP_RD);

`ifdef CSR_RO_CHECK_EN
    assign w_illegal = (r_addr[ADDR_W-1 -: 2] == 2'b11) && w_eff_wr;
`else
    assign w_illegal = 1'b0;
`endif

    csr_rmw_alu #(
        .DATA_W    (DATA_W),
        .MPP_VALUE (MPP_VALUE)
    ) u_alu (
        .i_op      (r_op),
        .i_old     (r_old),
        .i_wdata   (r_wdata),
        .o_new     (w_new),
        .o_mstatus (w_mstatus)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr_en <= 1'b0;
            r_old   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= csr_op_e'(req_op);
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wr_en <= req_wr_en;
            end
            if (r_state == S_I_WAIT || r_state == S_T_ST_WAIT) begin
                r_old <= csr_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (trap_valid) begin
                    w_next = S_T_EPC;
                end else if (req_valid) begin
                    w_next = S_I_RD;
                end
            end
            S_I_RD:      w_next = S_I_WAIT;
            S_I_WAIT:    w_next = S_I_WR;
            S_I_WR:      w_next = S_IDLE;
            S_T_EPC:     w_next = S_T_CAUSE;
            S_T_CAUSE:   w_next = S_T_TVAL;
            S_T_TVAL:    w_next = S_T_ST_RD;
            S_T_ST_RD:   w_next = S_T_ST_WAIT;
            S_T_ST_WAIT: w_next = S_T_ST_WR;
            S_T_ST_WR:   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid   = 1'b0;
        rsp_rdata   = '0;
        rsp_illegal = 1'b0;
        trap_done   = 1'b0;
        csr_addr    = '0;
        csr_we      = 1'b0;
        csr_wdata   = '0;
        case (r_state)
            S_I_RD, S_I_WAIT: begin
                csr_addr = r_addr;
            end
            S_I_WR: begin
                csr_addr    = r_addr;
                csr_wdata   = w_new;
                csr_we      = w_eff_wr && !w_illegal;
                rsp_valid   = 1'b1;
                rsp_rdata   = r_old;
                rsp_illegal = w_illegal;
            end
            S_T_EPC: begin
                csr_addr  = A_MEPC;
                csr_we    = 1'b1;
                csr_wdata = trap_pc & ~DATA_W'(3);
            end
            S_T_CAUSE: begin
                csr_addr  = A_MCAUSE;
                csr_we    = 1'b1;
                csr_wdata = trap_cause;
            end
            S_T_TVAL: begin
                csr_addr  = A_MTVAL;
                csr_we    = 1'b1;
                csr_wdata = trap_tval;
            end
            S_T_ST_RD, S_T_ST_WAIT: begin
                csr_addr = A_MSTATUS;
            end
            S_T_ST_WR: begin
                csr_addr  = A_MSTATUS;
                csr_we    = 1'b1;
                csr_wdata = w_mstatus;
                trap_done = 1'b1;
            end
            default: begin
                csr_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: CSR file model, request/trap drivers and a write/response scoreboard.
`timescale 1ns/1ps
module tb_csr_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wr_en;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        trap_done;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;

    int n_total = 0;
    int n_bad   = 0;

    logic [43:0] exp_wr_q[$];
    logic [32:0] exp_rsp_q[$];
    logic [31:0] csr_mem [0:4095];
    logic [31:0] ref_csr [0:4095];

    logic        poke_en;
    logic [11:0] poke_addr;
    logic [31:0] poke_data;
    time         t_done;
    time         t_acc;

    csr_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wr_en   (req_wr_en),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_illegal (rsp_illegal),
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .trap_done   (trap_done),
        .csr_addr    (csr_addr),
        .csr_rdata   (csr_rdata),
        .csr_we      (csr_we),
        .csr_wdata   (csr_wdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // CSR file with registered read data
    always @(posedge clk) begin
        csr_rdata <= csr_mem[csr_addr];
        if (poke_en) csr_mem[poke_addr] <= poke_data;
        else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rmw(input logic [1:0] op, input logic [31:0] old,
                                              input logic [31:0] wd);
        case (op)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] model_mstatus(input logic [31:0] old);
        logic [31:0] m;
        m        = old;
        m[7]     = old[3];
        m[3]     = 1'b0;
        m[12:11] = 2'b11;
        return m;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_we) begin
                chk("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    logic [43:0] e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(csr_addr), 64'(e[43:32]));
                    chk("wr_data", 64'(csr_wdata), 64'(e[31:0]));
                end
            end
            if (rsp_valid) begin
                chk("rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
                if (exp_rsp_q.size() != 0) begin
                    logic [32:0] r;
                    r = exp_rsp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(r[31:0]));
                    chk("rsp_illegal", 64'(rsp_illegal), 64'(r[32]));
                end
            end
        end
    end

    // driver tasks
    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        ref_csr[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic we);
        logic        acc;
        logic        got;
        logic        ill;
        logic        exp_we;
        logic [31:0] old;
        logic [31:0] nv;
        int          n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_wr_en = we;
        acc       = 1'b0;
        exp_we    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc   = 1'b1;
                t_acc = $time;
                old   = ref_csr[a];
                nv    = model_rmw(op, old, wd);
`ifdef CSR_RO_CHECK_EN
                ill = (a[11:10] == 2'b11) && we && (op != 2'b00);
`else
                ill = 1'b0;
`endif
                exp_we = we && (op != 2'b00) && !ill;
                exp_rsp_q.push_back({ill, old});
                if (exp_we) begin
                    exp_wr_q.push_back({a, nv});
                    ref_csr[a] = nv;
                end
                break;
            end
        end
        chk("req_accepted", 64'(acc), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        n   = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                chk("we_with_rsp", 64'(csr_we), 64'(exp_we));
                break;
            end
            n++;
        end
        chk("rsp_seen", 64'(got), 64'd1);
        chk("rsp_latency", 64'(n), 64'd3);
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input int exp_lat);
        logic done;
        int   n;
        @(posedge clk); #1;
        exp_wr_q.push_back({12'h341, pc & ~32'h3});
        exp_wr_q.push_back({12'h342, cause});
        exp_wr_q.push_back({12'h343, tval});
        exp_wr_q.push_back({12'h300, model_mstatus(ref_csr[12'h300])});
        ref_csr[12'h341] = pc & ~32'h3;
        ref_csr[12'h342] = cause;
        ref_csr[12'h343] = tval;
        ref_csr[12'h300] = model_mstatus(ref_csr[12'h300]);
        trap_pc    = pc;
        trap_cause = cause;
        trap_tval  = tval;
        trap_valid = 1'b1;
        done = 1'b0;
        n    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (trap_done) begin
                done   = 1'b1;
                t_done = $time;
                break;
            end
            n++;
        end
        chk("trap_done_seen", 64'(done), 64'd1);
        chk("trap_latency", 64'(n), 64'(exp_lat));
        @(posedge clk); #1;
        trap_valid = 1'b0;
    endtask

    initial begin
        int td_seen;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        req_wr_en  = 1'b0;
        trap_valid = 1'b0;
        trap_pc    = '0;
        trap_cause = '0;
        trap_tval  = '0;
        poke_en    = 1'b0;
        poke_addr  = '0;
        poke_data  = '0;
        t_done     = 0;
        t_acc      = 0;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
        chk("rst_trap_done", 64'(trap_done), 64'd0);
        chk("rst_csr_we", 64'(csr_we), 64'd0);
        chk("rst_csr_addr", 64'(csr_addr), 64'd0);
        chk("rst_csr_wdata", 64'(csr_wdata), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;

        poke(12'h340, 32'h0000_00F0);
        poke(12'h305, 32'h1234_5678);
        poke(12'h300, 32'h0000_0008);
        poke(12'hF11, 32'h0000_0000);

        do_req(2'b10, 12'h340, 32'h0F, 1'b1);         // RS -> 0xFF
        do_req(2'b11, 12'h340, 32'h0F, 1'b0);         // RC suppressed
        do_req(2'b01, 12'h340, 32'h1234, 1'b1);       // RW
        do_req(2'b11, 12'h340, 32'hF0, 1'b1);         // RC -> 0x1204
        do_req(2'b00, 12'h340, 32'hFFFF, 1'b1);       // read-only op
        do_req(2'b01, 12'hF11, 32'h1, 1'b1);          // read-only CSR space

        do_trap(32'h8000_0106, 32'd2, 32'hDEAD, 6);
        chk("mstatus_after_trap", 64'(csr_mem[12'h300]), 64'h1880);

        // trap and request raised together: trap first, request right after trap_done
        fork
            do_trap(32'h0000_0200, 32'd11, 32'h0, 6);
            do_req(2'b10, 12'h305, 32'h8000_0000, 1'b1);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("ready_blocked", 64'(req_ready), 64'd0);
            end
        join
        chk("acc_after_trap_done", 64'(t_acc - t_done), 64'd10);

        // trap raised while an instruction is in flight
        fork
            do_req(2'b01, 12'h340, 32'hCAFE, 1'b1);
            begin
                @(posedge clk);
                do_trap(32'h0000_0400, 32'd7, 32'h55, 9);
            end
        join

        // reset during T_CAUSE
        @(posedge clk); #1;
        trap_pc    = 32'h0000_0803;
        trap_cause = 32'd5;
        trap_tval  = 32'h77;
        trap_valid = 1'b1;
        exp_wr_q.push_back({12'h341, 32'h0000_0800});
        exp_wr_q.push_back({12'h342, 32'd5});
        ref_csr[12'h341] = 32'h0000_0800;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(csr_we), 64'd0);
        chk("rst_mid_trap_done", 64'(trap_done), 64'd0);
        trap_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        td_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (trap_done) td_seen++;
        end
        chk("no_trap_done_after_rst", 64'(td_seen), 64'd0);
        chk("mcause_unwritten", 64'(csr_mem[12'h342]), 64'd7);

        // random mix
        for (int k = 0; k < 20; k++) begin
            logic [11:0] a;
            case ($urandom_range(0, 2))
                0:       a = 12'h340;
                1:       a = 12'h305;
                default: a = 12'hF11;
            endcase
            do_req(2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
